// File: rtl/kmkz_writeback_pkg.sv
// Shared encodings and payload types for the Kamikaze-uRV writeback stage.
package kmkz_defs;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned FUN_W  = 3;
  localparam int unsigned SRC_W  = 2;

  // Result source select encodings (3 aliases the ALU/CSR result)
  localparam logic [SRC_W-1:0] RD_SOURCE_ALU      = 2'd0;
  localparam logic [SRC_W-1:0] RD_SOURCE_SHIFTER  = 2'd1;
  localparam logic [SRC_W-1:0] RD_SOURCE_MULTIPLY = 2'd2;

  // Load width/sign funct3 encodings
  localparam logic [FUN_W-1:0] LDST_B  = 3'b000;
  localparam logic [FUN_W-1:0] LDST_H  = 3'b001;
  localparam logic [FUN_W-1:0] LDST_L  = 3'b010;
  localparam logic [FUN_W-1:0] LDST_BU = 3'b100;
  localparam logic [FUN_W-1:0] LDST_HU = 3'b101;

  // Data-phase tracking FSM states
  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WAIT  = 2'd1,
    WB_ABORT = 2'd2
  } wb_state_e;

  // One register-file write port transaction
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  value;
    logic             write;
  } wb_write_t;

endpackage

// File: rtl/kmkz_load_align.sv
// Combinational aligner for AHB-Lite load data: byte/halfword select plus extension.
module kmkz_load_align
  import kmkz_defs::*;
(
  input  logic [FUN_W-1:0] fun,
  input  logic [1:0]       addr,
  input  logic [XLEN-1:0]  data,
  output logic [XLEN-1:0]  value,
  output logic             misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lanes
  always_comb begin
    byte_sel = data[7:0];
    case (addr)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    half_sel = addr[1] ? data[31:16] : data[15:0];
  end

  // Extend per funct3; unknown encodings behave as a full-word load
  always_comb begin
    value      = data;
    misaligned = 1'b0;
    case (fun)
      LDST_B:  value = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: value = {24'd0, byte_sel};
      LDST_H: begin
        value      = {{16{half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LDST_HU: begin
        value      = {16'd0, half_sel};
        misaligned = addr[0];
      end
      default: begin
        value      = data;
        misaligned = (addr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/kmkz_writeback.sv
// Writeback stage: result select, load alignment, rf write port, data-phase
// stall/timeout FSM and a registered bypass copy of the last write.
module kmkz_writeback
  import kmkz_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             w_stall_i,
  output logic             w_stall_req_o,
  input  logic             x_valid_i,
  input  logic             x_load_i,
  input  logic             x_store_i,
  input  logic [FUN_W-1:0] x_fun_i,
  input  logic [REG_W-1:0] x_rd_i,
  input  logic             x_rd_write_i,
  input  logic [SRC_W-1:0] x_rd_source_i,
  input  logic [XLEN-1:0]  x_rd_value_i,
  input  logic [XLEN-1:0]  x_shifter_value_i,
  input  logic [XLEN-1:0]  x_multiply_value_i,
  input  logic [XLEN-1:0]  x_dm_addr_i,
  input  logic [XLEN-1:0]  dm_data_l_i,
  input  logic             dm_ready_i,
  output logic [REG_W-1:0] rf_rd_o,
  output logic [XLEN-1:0]  rf_rd_value_o,
  output logic             rf_rd_write_o,
  output logic [REG_W-1:0] w_bypass_rd_o,
  output logic [XLEN-1:0]  w_bypass_value_o,
  output logic             w_bypass_write_o,
  output logic             w_retire_o,
  output logic             w_bus_error_o,
  output logic             w_misaligned_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  wb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  wb_write_t        bypass_q;

  logic [XLEN-1:0]  load_value;
  logic             load_misaligned;
  logic [XLEN-1:0]  src_value;
  logic             mem_pending;
  logic             in_abort;
  logic             completion;
  logic             bad_load;
  logic             unused_addr;

  assign unused_addr = ^x_dm_addr_i[XLEN-1:2];

  kmkz_load_align u_load_align (
    .fun        (x_fun_i),
    .addr       (x_dm_addr_i[1:0]),
    .data       (dm_data_l_i),
    .value      (load_value),
    .misaligned (load_misaligned)
  );

  // Non-load result source select
  always_comb begin
    src_value = x_rd_value_i;
    case (x_rd_source_i)
      RD_SOURCE_SHIFTER:  src_value = x_shifter_value_i;
      RD_SOURCE_MULTIPLY: src_value = x_multiply_value_i;
      default:            src_value = x_rd_value_i;
    endcase
  end

  assign mem_pending   = x_valid_i & (x_load_i | x_store_i);
  assign in_abort      = (state_q == WB_ABORT);
  assign w_stall_req_o = mem_pending & ~dm_ready_i & ~in_abort;
  assign completion    = x_valid_i & ~w_stall_req_o & ~in_abort;
  assign bad_load      = x_load_i & load_misaligned;

  assign rf_rd_o        = x_rd_i;
  assign rf_rd_value_o  = x_load_i ? load_value : src_value;
  assign rf_rd_write_o  = completion & x_rd_write_i & (x_rd_i != '0)
                          & ~x_store_i & ~bad_load;
  assign w_retire_o     = completion & ~w_stall_i;
  assign w_misaligned_o = completion & bad_load;
  assign w_bus_error_o  = in_abort;

  assign w_bypass_rd_o    = bypass_q.rd;
  assign w_bypass_value_o = bypass_q.value;
  assign w_bypass_write_o = bypass_q.write;

  // Saturating wait counter increment
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // FSM state and wait counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= WB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: track an outstanding data phase, abort after the timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WB_IDLE: begin
        cnt_d = '0;
        if (mem_pending && !dm_ready_i) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        cnt_d = cnt_inc;
        if (dm_ready_i || !mem_pending) begin
          state_d = WB_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= CNT_LIMIT) begin
          state_d = WB_ABORT;
        end
      end
      WB_ABORT: begin
        state_d = WB_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = WB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bypass copy of the write port, frozen by the global stall
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bypass_q <= '0;
    end else if (!w_stall_i) begin
      bypass_q.rd    <= rf_rd_o;
      bypass_q.value <= rf_rd_value_o;
      bypass_q.write <= rf_rd_write_o;
    end
  end

endmodule

// File: tb/tb_kmkz_writeback.sv
// Directed bench for kmkz_writeback with a short bus timeout.
module tb_kmkz_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        w_stall_i;
  logic        w_stall_req_o;
  logic        x_valid_i;
  logic        x_load_i;
  logic        x_store_i;
  logic [2:0]  x_fun_i;
  logic [4:0]  x_rd_i;
  logic        x_rd_write_i;
  logic [1:0]  x_rd_source_i;
  logic [31:0] x_rd_value_i;
  logic [31:0] x_shifter_value_i;
  logic [31:0] x_multiply_value_i;
  logic [31:0] x_dm_addr_i;
  logic [31:0] dm_data_l_i;
  logic        dm_ready_i;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_write_o;
  logic [4:0]  w_bypass_rd_o;
  logic [31:0] w_bypass_value_o;
  logic        w_bypass_write_o;
  logic        w_retire_o;
  logic        w_bus_error_o;
  logic        w_misaligned_o;

  int checks = 0;
  int errors = 0;

  kmkz_writeback #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .w_stall_i          (w_stall_i),
    .w_stall_req_o      (w_stall_req_o),
    .x_valid_i          (x_valid_i),
    .x_load_i           (x_load_i),
    .x_store_i          (x_store_i),
    .x_fun_i            (x_fun_i),
    .x_rd_i             (x_rd_i),
    .x_rd_write_i       (x_rd_write_i),
    .x_rd_source_i      (x_rd_source_i),
    .x_rd_value_i       (x_rd_value_i),
    .x_shifter_value_i  (x_shifter_value_i),
    .x_multiply_value_i (x_multiply_value_i),
    .x_dm_addr_i        (x_dm_addr_i),
    .dm_data_l_i        (dm_data_l_i),
    .dm_ready_i         (dm_ready_i),
    .rf_rd_o            (rf_rd_o),
    .rf_rd_value_o      (rf_rd_value_o),
    .rf_rd_write_o      (rf_rd_write_o),
    .w_bypass_rd_o      (w_bypass_rd_o),
    .w_bypass_value_o   (w_bypass_value_o),
    .w_bypass_write_o   (w_bypass_write_o),
    .w_retire_o         (w_retire_o),
    .w_bus_error_o      (w_bus_error_o),
    .w_misaligned_o     (w_misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Sample point for the cycle currently being driven
  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic drive_idle();
    w_stall_i          = 1'b0;
    x_valid_i          = 1'b0;
    x_load_i           = 1'b0;
    x_store_i          = 1'b0;
    x_fun_i            = 3'b010;
    x_rd_i             = 5'd0;
    x_rd_write_i       = 1'b0;
    x_rd_source_i      = 2'd0;
    x_rd_value_i       = 32'h1111_1111;
    x_shifter_value_i  = 32'h2222_2222;
    x_multiply_value_i = 32'h3333_3333;
    x_dm_addr_i        = 32'h0;
    dm_data_l_i        = 32'h0;
    dm_ready_i         = 1'b1;
  endtask

  task automatic drive_load(input logic [2:0] fun, input logic [4:0] rd,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic ready);
    drive_idle();
    x_valid_i    = 1'b1;
    x_load_i     = 1'b1;
    x_fun_i      = fun;
    x_rd_i       = rd;
    x_rd_write_i = 1'b1;
    x_dm_addr_i  = addr;
    dm_data_l_i  = data;
    dm_ready_i   = ready;
  endtask

  task automatic drive_alu(input logic [1:0] src, input logic [4:0] rd);
    drive_idle();
    x_valid_i     = 1'b1;
    x_rd_source_i = src;
    x_rd_i        = rd;
    x_rd_write_i  = 1'b1;
  endtask

  initial begin
    logic [31:0] src_exp [4];
    src_exp[0] = 32'h1111_1111;
    src_exp[1] = 32'h2222_2222;
    src_exp[2] = 32'h3333_3333;
    src_exp[3] = 32'h1111_1111;

    rst_i = 1'b0;
    drive_idle();
    sample();
    chk("rst_bypass_write", 32'(w_bypass_write_o), 32'h0);
    chk("rst_bypass_rd",    32'(w_bypass_rd_o),    32'h0);
    chk("rst_bypass_value", w_bypass_value_o,      32'h0);
    chk("rst_bus_error",    32'(w_bus_error_o),    32'h0);
    chk("rst_retire",       32'(w_retire_o),       32'h0);
    chk("rst_stall_req",    32'(w_stall_req_o),    32'h0);
    tick();
    rst_i = 1'b1;

    // LB from the top byte of the word, sign-extended
    tick();
    drive_load(3'b000, 5'd3, 32'h0000_1003, 32'h8012_3456, 1'b1);
    sample();
    chk("lb_value",   rf_rd_value_o,          32'hFFFF_FF80);
    chk("lb_write",   32'(rf_rd_write_o),     32'h1);
    chk("lb_rd",      32'(rf_rd_o),           32'd3);
    chk("lb_stall",   32'(w_stall_req_o),     32'h0);
    chk("lb_retire",  32'(w_retire_o),        32'h1);
    chk("lb_misal",   32'(w_misaligned_o),    32'h0);

    // LHU upper half; bypass now reflects the LB
    tick();
    drive_load(3'b101, 5'd4, 32'h0000_0002, 32'hBEEF_1234, 1'b1);
    sample();
    chk("lhu_value",   rf_rd_value_o,         32'h0000_BEEF);
    chk("byp_lb_rd",   32'(w_bypass_rd_o),    32'd3);
    chk("byp_lb_val",  w_bypass_value_o,      32'hFFFF_FF80);
    chk("byp_lb_wr",   32'(w_bypass_write_o), 32'h1);

    tick();
    drive_load(3'b001, 5'd4, 32'h0000_0002, 32'hBEEF_1234, 1'b1);
    sample();
    chk("lh_value",   rf_rd_value_o,          32'hFFFF_BEEF);

    // Result source select for all four encodings
    for (int s = 0; s < 4; s++) begin
      tick();
      drive_alu(2'(s), 5'd9);
      sample();
      chk("src_value", rf_rd_value_o,      src_exp[s]);
      chk("src_write", 32'(rf_rd_write_o), 32'h1);
    end

    // Write to x0 is suppressed but still retires
    tick();
    drive_alu(2'd0, 5'd0);
    sample();
    chk("x0_write",  32'(rf_rd_write_o), 32'h0);
    chk("x0_retire", 32'(w_retire_o),    32'h1);

    // Store never writes rd
    tick();
    drive_idle();
    x_valid_i = 1'b1; x_store_i = 1'b1; x_rd_i = 5'd4; x_rd_write_i = 1'b1;
    sample();
    chk("st_write", 32'(rf_rd_write_o), 32'h0);

    // Misaligned LW
    tick();
    drive_load(3'b010, 5'd6, 32'h0000_0002, 32'h1234_5678, 1'b1);
    sample();
    chk("mis_pulse", 32'(w_misaligned_o), 32'h1);
    chk("mis_write", 32'(rf_rd_write_o),  32'h0);

    // LW with 3 wait cycles; ready arrives as the counter hits its limit
    for (int c = 0; c < 3; c++) begin
      tick();
      drive_load(3'b010, 5'd5, 32'h0000_0100, 32'hCAFE_F00D, 1'b0);
      sample();
      chk("lw_wait_stall", 32'(w_stall_req_o), 32'h1);
      chk("lw_wait_write", 32'(rf_rd_write_o), 32'h0);
      chk("lw_wait_err",   32'(w_bus_error_o), 32'h0);
    end
    tick();
    drive_load(3'b010, 5'd5, 32'h0000_0100, 32'hCAFE_F00D, 1'b1);
    sample();
    chk("lw_done_stall",  32'(w_stall_req_o), 32'h0);
    chk("lw_done_write",  32'(rf_rd_write_o), 32'h1);
    chk("lw_done_value",  rf_rd_value_o,      32'hCAFE_F00D);
    chk("lw_done_retire", 32'(w_retire_o),    32'h1);
    chk("lw_done_err",    32'(w_bus_error_o), 32'h0);
    tick();
    drive_idle();
    sample();
    chk("lw_byp_rd",  32'(w_bypass_rd_o),    32'd5);
    chk("lw_byp_val", w_bypass_value_o,      32'hCAFE_F00D);
    chk("lw_byp_wr",  32'(w_bypass_write_o), 32'h1);

    // Timeout on a misaligned load: 4 stall cycles then one abort cycle
    for (int c = 0; c < 4; c++) begin
      tick();
      drive_load(3'b010, 5'd7, 32'h0000_0001, 32'h0, 1'b0);
      sample();
      chk("to_stall", 32'(w_stall_req_o), 32'h1);
      chk("to_err",   32'(w_bus_error_o), 32'h0);
    end
    tick();
    sample();
    chk("abort_stall",  32'(w_stall_req_o),  32'h0);
    chk("abort_err",    32'(w_bus_error_o),  32'h1);
    chk("abort_write",  32'(rf_rd_write_o),  32'h0);
    chk("abort_retire", 32'(w_retire_o),     32'h0);
    chk("abort_misal",  32'(w_misaligned_o), 32'h0);
    tick();
    drive_idle();
    sample();
    chk("post_abort_err", 32'(w_bus_error_o), 32'h0);

    // Valid drops while waiting: back to idle without an error
    for (int c = 0; c < 2; c++) begin
      tick();
      drive_load(3'b010, 5'd8, 32'h0, 32'h0, 1'b0);
      sample();
    end
    tick();
    drive_idle();
    sample();
    chk("drop_stall", 32'(w_stall_req_o), 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      sample();
      chk("drop_err", 32'(w_bus_error_o), 32'h0);
    end

    // Global stall freezes the bypass and blocks retire
    tick();
    drive_alu(2'd0, 5'd10);
    sample();
    tick();
    drive_alu(2'd1, 5'd11);
    w_stall_i = 1'b1;
    sample();
    chk("gs_retire",  32'(w_retire_o),     32'h0);
    chk("gs_rf_wr",   32'(rf_rd_write_o),  32'h1);
    chk("gs_byp_rd",  32'(w_bypass_rd_o),  32'd10);
    tick();
    drive_idle();
    sample();
    chk("gs_hold_rd",  32'(w_bypass_rd_o),  32'd10);
    chk("gs_hold_val", w_bypass_value_o,    32'h1111_1111);

    // Reset in the middle of a wait
    for (int c = 0; c < 2; c++) begin
      tick();
      drive_load(3'b010, 5'd12, 32'h0, 32'h0, 1'b0);
      sample();
    end
    tick();
    rst_i = 1'b0;
    drive_idle();
    sample();
    chk("mrst_byp_wr", 32'(w_bypass_write_o), 32'h0);
    chk("mrst_err",    32'(w_bus_error_o),    32'h0);
    tick();
    rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      sample();
      chk("mrst_post_err",    32'(w_bus_error_o), 32'h0);
      chk("mrst_post_retire", 32'(w_retire_o),    32'h0);
    end
    // Counter restarts from zero after reset: a fresh wait needs 4 stall cycles
    for (int c = 0; c < 4; c++) begin
      tick();
      drive_load(3'b010, 5'd13, 32'h0, 32'h0, 1'b0);
      sample();
      chk("mrst_to_stall", 32'(w_stall_req_o), 32'h1);
    end
    tick();
    sample();
    chk("mrst_to_err", 32'(w_bus_error_o), 32'h1);
    tick();
    drive_idle();
    sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kmkz_writeback.md
# kmkz_writeback

Writeback stage of the Kamikaze-uRV pipeline, directly downstream of the execute stage. It consumes the X/W pipeline register outputs and completes each instruction:
- aligns and sign-extends load data from the AHB-Lite data phase
- selects the result source
- drives the register-file write port
- requests a stall while a memory data phase is outstanding
- aborts hung bus transfers through a timeout FSM
- provides a registered bypass copy of the last committed write for operand forwarding

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: wait cycles before an outstanding data phase is aborted; legal range 1..65535.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- w_stall_i  in  1  global pipeline stall
- w_stall_req_o  out  1  stall request to pipeline control
- x_valid_i  in  1  W-stage instruction valid
- x_load_i / x_store_i  in  1  instruction is load / store
- x_fun_i  in  3  load width and sign (funct3)
- x_rd_i  in  5  destination register
- x_rd_write_i  in  1  instruction writes rd
- x_rd_source_i  in  2  result source select
- x_rd_value_i  in  32  ALU/CSR result
- x_shifter_value_i  in  32  shifter result
- x_multiply_value_i  in  32  multiplier result
- x_dm_addr_i  in  32  load/store address
- dm_data_l_i  in  32  AHB-Lite read data
- dm_ready_i  in  1  AHB-Lite data phase complete
- rf_rd_o  out  5  register-file write index
- rf_rd_value_o  out  32  register-file write data
- rf_rd_write_o  out  1  register-file write enable
- w_bypass_rd_o  out  5  registered copy of last write index
- w_bypass_value_o  out  32  registered copy of last write data
- w_bypass_write_o  out  1  registered copy of last write enable
- w_retire_o  out  1  one-cycle pulse per completed instruction
- w_bus_error_o  out  1  one-cycle pulse on timeout abort
- w_misaligned_o  out  1  one-cycle pulse on misaligned load

## Operation
- Result source select:
  - 0: x_rd_value_i
  - 1: x_shifter_value_i
  - 2: x_multiply_value_i
  - 3: x_rd_value_i
  - A load overrides the source select with the aligned load data.
- Load alignment (a = x_dm_addr_i[1:0]):
  - LB/LBU: byte a, sign-/zero-extended.
  - LH/LHU: halfword a[1], sign-/zero-extended.
  - LW: full word.
  - Other funct3: treated as LW.
- Misaligned load (LH/LHU with a[0]=1, or LW with a≠0): no rf write; w_misaligned_o pulses on the completing cycle.
- mem_pending = x_valid_i & (x_load_i | x_store_i).
- FSM, 2-bit state:
  - IDLE: if mem_pending & !dm_ready_i, go to WAIT and clear the counter. Otherwise the instruction completes this cycle.
  - WAIT: counter increments each cycle. If dm_ready_i, complete and go to IDLE. If counter reaches TIMEOUT_CYCLES-1 without ready, go to ABORT.
  - ABORT: lasts exactly one cycle. Stall is released, no rf write, w_bus_error_o=1; then IDLE.
- w_stall_req_o = mem_pending & !dm_ready_i & (state≠ABORT). Combinational.
- Completion: x_valid_i & !w_stall_req_o & state≠ABORT.
- rf_rd_write_o = completion & x_rd_write_i & (x_rd_i≠0) & !misaligned. Stores never write.
- w_retire_o = completion & !w_stall_i. Aborted instructions do not retire.
- Bypass registers load rf_rd_o / rf_rd_value_o / rf_rd_write_o on every cycle with !w_stall_i; they hold while w_stall_i is high.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Timing
- Register-file write port is combinational from the W inputs: zero-latency commit in the completing cycle.
- Load data is sampled in the cycle dm_ready_i is high. The write occurs in that same cycle.
- Bypass outputs lag the rf write port by exactly one non-stalled cycle.
- Reset values:
  - State IDLE, counter 0.
  - w_bypass_* = 0.
  - All pulse outputs 0.
  - Combinational outputs follow their inputs.
- Reset asserted mid-WAIT: returns to IDLE immediately; no write, no error pulse.
- x_valid_i dropping while in WAIT: return to IDLE, no error pulse.
- dm_ready_i high in the same cycle the counter reaches its limit: the ready wins, and the load completes normally.
- Misaligned and timeout together: the timeout takes precedence, and only w_bus_error_o pulses.

## Structure
- kmkz_defs holds:
  - RD_SOURCE_ALU/SHIFTER/MULTIPLY encodings
  - LDST_B/H/L/BU/HU funct3 constants
  - WB_IDLE/WB_WAIT/WB_ABORT state encodings
- Sub-module kmkz_load_align: combinational load-data aligner, with inputs fun, addr[1:0], data and outputs value, misaligned.

## Test plan
- LB at addr 0x1003, data 0x80123456 -> rf_rd_value_o=0xFFFFFF80, write in the same cycle.
- LHU at addr 0x0002, data 0xBEEF1234 -> 0x0000BEEF. LH with the same stimulus -> 0xFFFFBEEF.
- LW, rd=5, dm_ready_i low for 3 cycles -> w_stall_req_o high 3 cycles; write of rd=5 on cycle 4; bypass shows rd=5 on cycle 5.
- TIMEOUT_CYCLES=4, ready never asserted -> 4 stall cycles, then 1 ABORT cycle with w_bus_error_o=1, no write, no retire.
- ALU op with rd=0 -> rf_rd_write_o=0. LW at addr 0x2 -> w_misaligned_o=1, no write.
- rst_i low during WAIT -> state IDLE, w_bypass_write_o=0, no pulses after release.
